pc_sequencer: RTL and testbench

- Parametrised, registered program-counter sequencer for the single-cycle MIPS core; successor to the combinational next-PC logic.
- Owns the PC register and computes the next PC each clock from sequential, branch (BEQ/BNE), absolute-jump, register-jump and call/return requests.
- Adds a return-address stack (RAS) and a halt/resume handshake with sticky stack-error flags.
- Its output addresses instruction memory directly.

---
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the single-cycle MIPS core. It handles
// sequential, branch, jump, register-jump and call/return flow, using a circular
// return-address stack.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 11,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halt,
  input  logic            ok,
  input  logic            branch,
  input  logic            bne,
  input  logic            zero,
  input  logic            j,
  input  logic            call,
  input  logic            jr,
  input  logic            ret,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [PC_W-1:0] rs_value,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_JUMP,
    ACT_CALL,
    ACT_JR,
    ACT_POP,
    ACT_UNDER,
    ACT_BRANCH
  } act_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  act_e              act;
  logic              push;
  logic              full;
  logic [PC_W-1:0]   inc;
  logic [PC_W-1:0]   br_tgt;
  logic [PTR_W-1:0]  top_idx;
  logic signed [31:0] sext;
  logic              unused_bits;

  assign full        = (cnt_q == CNT_W'(RAS_DEPTH));
  assign inc         = pc_q + PC_W'(1);
  assign sext        = 32'(signed'(imm16));
  assign br_tgt      = pc_q + sext[PC_W-1:0];
  // ptr_q addresses the next free slot, so the newest entry sits just below it
  assign top_idx     = ptr_q - PTR_W'(1);
  assign unused_bits = ^{imm26, sext};

  always_comb begin
    act = ACT_INC;
    if (halt && !ok)                       act = ACT_HOLD;
    else if (halt)                         act = ACT_INC;
    else if (call)                         act = ACT_CALL;
    else if (j)                            act = ACT_JUMP;
    else if (jr)                           act = ACT_JR;
    else if (ret)                          act = (cnt_q != '0) ? ACT_POP : ACT_UNDER;
    else if ((branch && zero) || (bne && !zero)) act = ACT_BRANCH;
  end

  always_comb begin
    pc_d  = inc;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    unique case (act)
      ACT_HOLD:   pc_d = pc_q;
      ACT_INC:    pc_d = inc;
      ACT_JUMP:   pc_d = imm26[PC_W-1:0];
      ACT_CALL: begin
        // when full, the write pointer has wrapped onto the oldest entry
        pc_d  = imm26[PC_W-1:0];
        push  = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CNT_W'(1);
      end
      ACT_JR:     pc_d = rs_value;
      ACT_POP: begin
        pc_d  = ras_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
      ACT_UNDER: begin
        pc_d  = inc;
        unf_d = 1'b1;
      end
      ACT_BRANCH: pc_d = br_tgt;
      default:    pc_d = inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) ras_q[ptr_q] <= inc;
  end

  assign pc_out        = pc_q;
  assign halted        = halt & ~ok;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each edge,
// and a monitor compares the DUT after every rising clock edge.
module tb_pc_sequencer;

  localparam int unsigned PC_W      = 11;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int          MASK      = (1 << PC_W) - 1;

  logic            clock = 1'b0;
  logic            reset, halt, ok, branch, bne, zero, j, call, jr, ret;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  logic [PC_W-1:0] rs_value;
  logic [PC_W-1:0] pc_out;
  logic            halted, ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .halt(halt), .ok(ok), .branch(branch), .bne(bne),
    .zero(zero), .j(j), .call(call), .jr(jr), .ret(ret), .imm16(imm16), .imm26(imm26),
    .rs_value(rs_value), .pc_out(pc_out), .halted(halted), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit reset, halt, ok, branch, bne, zero, j, call, jr, ret;
    logic [15:0] imm16;
    logic [25:0] imm26;
    int rs;
  } stim_t;

  typedef struct {
    int pc;
    bit empty, full, ovf, unf, halted;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passes = 0;

  int   m_pc  = 0;
  int   m_ras[$];
  bit   m_ovf = 0;
  bit   m_unf = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want)
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    else
      passes++;
  endtask

  // Reference model: RAS is a plain queue, newest entry at the back.
  task automatic model(input stim_t s);
    int inc;
    int off;
    inc = (m_pc + 1) & MASK;
    if (s.reset) begin
      m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
    end else if (s.halt && !s.ok) begin
      m_pc = m_pc;
    end else if (s.halt) begin
      m_pc = inc;
    end else if (s.j || s.call) begin
      if (s.call) begin
        m_ras.push_back(inc);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
      end
      m_pc = int'(s.imm26) & MASK;
    end else if (s.jr) begin
      m_pc = s.rs & MASK;
    end else if (s.ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = inc; m_unf = 1; end
    end else if ((s.branch && s.zero) || (s.bne && !s.zero)) begin
      off  = $signed(s.imm16);
      m_pc = (m_pc + off) & MASK;
    end else begin
      m_pc = inc;
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    reset = s.reset; halt = s.halt; ok = s.ok; branch = s.branch; bne = s.bne;
    zero = s.zero; j = s.j; call = s.call; jr = s.jr; ret = s.ret;
    imm16 = s.imm16; imm26 = s.imm26; rs_value = PC_W'(s.rs);
    model(s);
    e.pc     = m_pc;
    e.empty  = (m_ras.size() == 0);
    e.full   = (m_ras.size() == RAS_DEPTH);
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.halted = s.halt & ~s.ok;
    expq.push_back(e);
    @(negedge clock);
  endtask

  task automatic do_idle();       apply(idle()); endtask
  task automatic do_reset();      stim_t s = idle(); s.reset = 1; apply(s); endtask
  task automatic do_jr(int v);    stim_t s = idle(); s.jr = 1; s.rs = v; apply(s); endtask
  task automatic do_call(int t);  stim_t s = idle(); s.call = 1; s.imm26 = 26'(t); apply(s); endtask
  task automatic do_ret();        stim_t s = idle(); s.ret = 1; apply(s); endtask
  task automatic do_br(bit b, bit n, bit z, logic [15:0] off);
    stim_t s = idle();
    s.branch = b; s.bne = n; s.zero = z; s.imm16 = off;
    apply(s);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_out",        32'(pc_out),   e.pc);
        chk("ras_empty",     32'(ras_empty), 32'(e.empty));
        chk("ras_full",      32'(ras_full),  32'(e.full));
        chk("ras_overflow",  32'(ras_overflow),  32'(e.ovf));
        chk("ras_underflow", 32'(ras_underflow), 32'(e.unf));
        chk("halted",        32'(halted),    32'(e.halted));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t s;
    // reset and sequential flow, then wrap from all-ones
    do_reset();
    repeat (3) do_idle();
    do_jr(2047);
    do_idle();
    // branches relative to the current PC
    do_jr(10); do_br(1, 0, 1, 16'd5);
    do_jr(10); do_br(1, 0, 1, 16'hFFFD);
    do_jr(10); do_br(0, 1, 1, 16'd5);
    do_jr(10); do_br(0, 1, 0, 16'd0);
    // halt holds the PC even with a jump asserted; ok releases it
    do_jr(20);
    repeat (3) begin
      s = idle(); s.halt = 1; s.j = 1; s.imm26 = 26'd100; apply(s);
    end
    s = idle(); s.halt = 1; s.ok = 1; s.j = 1; s.imm26 = 26'd100; apply(s);
    // nested call/ret
    do_jr(4); do_call(50); do_call(80); do_ret(); do_ret();
    // j and call together behave as a call
    s = idle(); s.j = 1; s.call = 1; s.imm26 = 26'd300; apply(s);
    do_ret();
    // RAS overflow and underflow boundaries
    do_reset(); do_idle();
    for (int i = 1; i <= 5; i++) do_call(i + 1);
    repeat (5) do_ret();
    // reset while halted with a partly filled stack
    do_reset(); do_call(30); do_call(40);
    s = idle(); s.reset = 1; s.halt = 1; s.ret = 1; apply(s);
    do_ret();
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.reset  = ($urandom_range(0, 63) == 0);
      s.halt   = ($urandom_range(0, 7) == 0);
      s.ok     = $urandom_range(0, 1);
      s.branch = ($urandom_range(0, 4) == 0);
      s.bne    = ($urandom_range(0, 4) == 0);
      s.zero   = $urandom_range(0, 1);
      s.j      = ($urandom_range(0, 9) == 0);
      s.call   = ($urandom_range(0, 5) == 0);
      s.jr     = ($urandom_range(0, 11) == 0);
      s.ret    = ($urandom_range(0, 4) == 0);
      s.imm16  = 16'($urandom);
      s.imm26  = 26'($urandom);
      s.rs     = int'($urandom_range(0, MASK));
      apply(s);
    end
    do_idle();
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
